pw_boot_loader: RTL



---
 rtl/pw_boot_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pw_boot_loader.sv
// pw_boot_loader
//   Boot loader and run/halt controller for the Picowizard CPU. After reset
//   or a boot request it holds the CPU disabled. It then receives a program
//   image over a byte stream with the layout:
//     LenHi, LenLo, payload[Len], checksum
//   Each payload byte n is written to LOAD_BASE+n. The checksum must equal
//   the XOR of all payload bytes. On a match the memory bus is handed to the
//   CPU and CPUEn is raised. On a mismatch Err is raised and the loader waits
//   for Rst or BootReq.
//
// Ports
//   Clk, Rst       clock and synchronous active-high reset
//   BootReq        single-cycle restart request
//   RxData/RxValid/RxReady   image byte stream (valid/ready handshake)
//   CpuAdr, CpuDataOut, CpuLdMem, CpuWrtMem   CPU-side bus, used only in RUN
//   CpuDataIn      read data returned to the CPU (always MemRData)
//   MemRData       read data from the memory
//   MemAdr, MemWData, MemWe, MemRe            memory-side bus
//   CPUEn          registered CPU enable
//   Busy           loader is consuming an image
//   Err            registered, sticky checksum mismatch flag
module pw_boot_loader #(
  parameter int ADR_W     = 16,
  parameter int LOAD_BASE = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             BootReq,
  input  logic [7:0]       RxData,
  input  logic             RxValid,
  output logic             RxReady,
  input  logic [ADR_W-1:0] CpuAdr,
  input  logic [7:0]       CpuDataOut,
  input  logic             CpuLdMem,
  input  logic             CpuWrtMem,
  output logic [7:0]       CpuDataIn,
  input  logic [7:0]       MemRData,
  output logic             CPUEn,
  output logic [ADR_W-1:0] MemAdr,
  output logic [7:0]       MemWData,
  output logic             MemWe,
  output logic             MemRe,
  output logic             Busy,
  output logic             Err
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    LOAD   = 3'd2,
    CHECK  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [ADR_W-1:0] BASE_ADR = ADR_W'(LOAD_BASE);

  state_t      state_reg;
  logic [15:0] len_reg;
  logic [15:0] count_reg;
  logic [7:0]  csum_reg;
  logic        cpu_en_reg;
  logic        err_reg;

  logic        handshake;

  assign Busy      = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                     (state_reg == LOAD)   || (state_reg == CHECK);
  assign RxReady   = Busy;
  assign handshake = RxValid & RxReady;
  assign CPUEn     = cpu_en_reg;
  assign Err       = err_reg;
  assign CpuDataIn = MemRData;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= LEN_HI;
      len_reg    <= 16'h0000;
      count_reg  <= 16'h0000;
      csum_reg   <= 8'h00;
      cpu_en_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else if (BootReq) begin
      // Restart; any byte handshaken in this cycle is dropped.
      state_reg  <= LEN_HI;
      count_reg  <= 16'h0000;
      csum_reg   <= 8'h00;
      cpu_en_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        LEN_HI: begin
          if (handshake) begin
            len_reg[15:8] <= RxData;
            state_reg     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (handshake) begin
            len_reg[7:0] <= RxData;
            // An empty image goes straight to the checksum byte.
            if ({len_reg[15:8], RxData} == 16'h0000) begin
              state_reg <= CHECK;
            end else begin
              count_reg <= 16'h0000;
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (handshake) begin
            csum_reg  <= csum_reg ^ RxData;
            count_reg <= count_reg + 16'd1;
            if (count_reg == len_reg - 16'd1) begin
              state_reg <= CHECK;
            end
          end
        end
        CHECK: begin
          if (handshake) begin
            if (RxData == csum_reg) begin
              state_reg  <= RUN;
              cpu_en_reg <= 1'b1;
            end else begin
              state_reg <= ERROR;
              err_reg   <= 1'b1;
            end
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        ERROR: begin
          cpu_en_reg <= 1'b0;
          state_reg  <= ERROR;
        end
        default: begin
          state_reg <= LEN_HI;
        end
      endcase
    end
  end

  // Memory bus steering. While loading, the write strobe is also masked by
  // Rst and BootReq so that a byte presented in a restart cycle never lands
  // in memory.
  always_comb begin
    MemAdr   = '0;
    MemWData = 8'h00;
    MemWe    = 1'b0;
    MemRe    = 1'b0;
    case (state_reg)
      LOAD: begin
        MemAdr   = BASE_ADR + ADR_W'(count_reg);
        MemWData = RxData;
        MemWe    = RxValid & ~Rst & ~BootReq;
      end
      RUN: begin
        MemAdr   = CpuAdr;
        MemWData = CpuDataOut;
        MemWe    = CpuWrtMem;
        MemRe    = CpuLdMem;
      end
      default: begin
        MemAdr   = '0;
        MemWData = 8'h00;
        MemWe    = 1'b0;
        MemRe    = 1'b0;
      end
    endcase
  end

endmodule
